cim_accum_core: RTL and testbench
=================================

# cim_accum_core

Multi-column compute-in-memory core with an on-block accumulate sequencer. Each memory row holds `NUM_COL` signed-magnitude weights. On `start`, the block streams `len_m1+1` activations through a valid/ready handshake and reads consecutive rows, wrapping at the end of memory. It multiplies each activation by every column weight and accumulates per column in two's complement, then presents the `NUM_COL` dot products on a valid/ready output. It replaces the single-word, single-product core as the dot-product engine feeding the downstream layer logic.

## Interface
- `XIN_BIT_WIDTH`, 11, activation width; sign-magnitude, MSB is the sign.
- `MEM_BIT_WIDTH`, 8, per-column weight width; sign-magnitude, MSB is the sign.
- `MEM_ADR_WIDTH`, 4, row address width; `MEM_DEPTH = 1<<MEM_ADR_WIDTH` (16).
- `NUM_COL`, 4, number of weight columns per row.
- `ACC_BIT_WIDTH`, `XIN_BIT_WIDTH+MEM_BIT_WIDTH-1+MEM_ADR_WIDTH` (22), per-column two's-complement accumulator width.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset; synchronous and active-high.
- `web`  in  1  write enable, active-low.
- `wadr`  in  MEM_ADR_WIDTH  write row address.
- `din`  in  NUM_COL*MEM_BIT_WIDTH  write row data; column c is at `din[c*MEM_BIT_WIDTH +: MEM_BIT_WIDTH]`.
- `start`  in  1  begin a job; sampled only in IDLE.
- `base_adr`  in  MEM_ADR_WIDTH  first row of the job; sampled with `start`.
- `len_m1`  in  MEM_ADR_WIDTH  number of beats minus 1 (1..MEM_DEPTH beats); sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `xin`  in  XIN_BIT_WIDTH  activation.
- `xin_valid`  in  1  activation valid.
- `xin_ready`  out  1  activation accepted when `xin_valid & xin_ready`.
- `dout`  out  NUM_COL*ACC_BIT_WIDTH  results; column c is at `dout[c*ACC_BIT_WIDTH +: ACC_BIT_WIDTH]`.
- `dout_valid`  out  1  results valid.
- `dout_ready`  in  1  downstream accepts the results.

## Operation
- **Memory**
  - `MEM_DEPTH` x `NUM_COL*MEM_BIT_WIDTH` array, 1 write port and 1 read port.
  - A write occurs on a posedge with `web=0`, in any state, including during a job.
  - Read is registered: data for an address issued in cycle N is available in cycle N+1.
  - A write and a read to the same row in the same cycle return the OLD data.
  - Memory contents are not affected by `rst`.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start`. On that edge: `ptr <= base_adr`, `cnt <= len_m1`, all accumulators are cleared.
  - RUN: `xin_ready=1`. Each accepted beat:
    - issues a read at `ptr`;
    - registers `xin` and a beat-valid flag;
    - `ptr <= ptr+1` modulo `MEM_DEPTH` (wraps from 15 to 0);
    - `cnt <= cnt-1`.
  - RUN -> DRAIN on the beat accepted with `cnt==0`.
  - DRAIN: `xin_ready=0`. The final product is accumulated. Goes to DONE unconditionally after 1 cycle.
  - DONE: `dout_valid=1`. `dout` holds the accumulators and is stable until `dout_ready`. On `dout_valid & dout_ready` -> IDLE.
  - `start` outside IDLE is ignored.
- **Accumulate:** in the cycle after an accepted beat (in RUN or DRAIN), for each column c:
  - `mag = w_c[MEM-2:0] * x[XIN-2:0]`, an `(XIN+MEM-2)`-bit unsigned value.
  - `sgn = w_c[MEM-1] ^ x[XIN-1]`.
  - `term = sgn ? -mag : +mag`, zero-extended before negation to `ACC_BIT_WIDTH`. Negative zero (magnitude 0) contributes 0.
  - `acc_c <= acc_c + term`.
- **Width rule:** the worst case is `|sum| = MEM_DEPTH*(2^(XIN-1)-1)*(2^(MEM-1)-1)` = 2,078,736 at defaults, which is < 2^21. Overflow is therefore impossible and is not checked.
- **Reset:** takes effect on any cycle, including mid-job. FSM -> IDLE; accumulators, `ptr`, `cnt` and the beat-valid flag -> 0. Any in-flight beat is discarded.

## Timing
- **Reset values:** `busy=0`, `xin_ready=0`, `dout_valid=0`, `dout=0`.
- **Latency:** with `start` in cycle T and `xin_valid` held high:
  - RUN is cycles T+1..T+len;
  - DRAIN is cycle T+len+1;
  - `dout_valid` rises in cycle T+len+2, where len = `len_m1+1`.
- **Backpressure:**
  - A gap in `xin_valid` stalls the job by the same number of cycles; no beat is lost or duplicated.
  - `xin_ready` depends only on state, never on `xin_valid`.
- **Output:** `dout_valid` falls in the cycle after the handshake. `dout` keeps its last value while IDLE; it is cleared only by `rst` or by the next `start`.
- **Throughput:** the earliest new `start` is accepted in the cycle after DONE exits (IDLE for at least 1 cycle).

## Test plan
- **Single beat:** write row 0 = {c0:+3, c1:-5 (0x85), c2:+127, c3:0}; `start` with base 0, len_m1 0, `xin=+2` -> `dout` = {6, -10, 254, 0}, `dout_valid` at T+3.
- **Full depth, sign:** all rows all columns 0x7F, len_m1 15, `xin=0x3FF` every beat -> every column 2,078,736. Rerun with `xin=0x7FF` -> every column -2,078,736.
- **Wrap and negative zero:** rows 14, 15, 0, 1 = +1, +2, +3, 0x80 in every column; base 14, len_m1 3, `xin=+10` -> each column 60.
- **Backpressure:** `xin_valid` toggles 1,0,0,1,... over 4 beats; `dout_ready` low for 5 cycles after `dout_valid` -> correct sum, `dout` stable throughout, `dout_valid` drops 1 cycle after `dout_ready`.
- **Write hazard:** in RUN, write row N with new data in the same cycle as the beat that reads row N -> the old data is used. A subsequent job sees the new data.
- **Reset mid-job:** assert `rst` in RUN after 2 of 4 beats -> next cycle `busy=0`, `xin_ready=0`, `dout=0`. A new job returns the correct sum and memory contents are intact.

Source files
------------

// File: rtl/cim_accum_core_if.sv
// Bundle of write-port, job-control, activation-stream and result-stream
// signals shared between the accumulate core and whatever drives it.
interface cim_accum_core_if #(
  parameter int XIN_BIT_WIDTH = 11,
  parameter int MEM_BIT_WIDTH = 8,
  parameter int MEM_ADR_WIDTH = 4,
  parameter int NUM_COL       = 4,
  parameter int ACC_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1 + MEM_ADR_WIDTH
);
  logic                               web;
  logic [MEM_ADR_WIDTH-1:0]           wadr;
  logic [NUM_COL*MEM_BIT_WIDTH-1:0]   din;
  logic                               start;
  logic [MEM_ADR_WIDTH-1:0]           base_adr;
  logic [MEM_ADR_WIDTH-1:0]           len_m1;
  logic                               busy;
  logic [XIN_BIT_WIDTH-1:0]           xin;
  logic                               xin_valid;
  logic                               xin_ready;
  logic [NUM_COL*ACC_BIT_WIDTH-1:0]   dout;
  logic                               dout_valid;
  logic                               dout_ready;

  modport master (
    output web, wadr, din, start, base_adr, len_m1, xin, xin_valid, dout_ready,
    input  busy, xin_ready, dout, dout_valid
  );

  modport slave (
    input  web, wadr, din, start, base_adr, len_m1, xin, xin_valid, dout_ready,
    output busy, xin_ready, dout, dout_valid
  );
endinterface

// File: rtl/cim_accum_core.sv
// Multi-column compute-in-memory dot-product engine: streams activations against
// consecutive weight rows and accumulates one signed sum per column.
module cim_accum_core #(
  parameter int XIN_BIT_WIDTH = 11,
  parameter int MEM_BIT_WIDTH = 8,
  parameter int MEM_ADR_WIDTH = 4,
  parameter int NUM_COL       = 4,
  parameter int ACC_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1 + MEM_ADR_WIDTH
) (
  input logic             clk,
  input logic             rst,
  cim_accum_core_if.slave bus
);
  localparam int MEM_DEPTH = 1 << MEM_ADR_WIDTH;
  localparam int ROW_W     = NUM_COL * MEM_BIT_WIDTH;
  localparam int MAG_W     = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [MEM_ADR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [MEM_ADR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       beat_q, beat_d;
  logic [XIN_BIT_WIDTH-1:0]   x_q, x_d;
  logic                       clear_acc;

  logic [ROW_W-1:0]           mem [MEM_DEPTH];
  logic [ROW_W-1:0]           rd_data_q;
  logic [NUM_COL*ACC_BIT_WIDTH-1:0] dout_w;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    beat_d    = 1'b0;
    x_d       = x_q;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          ptr_d     = bus.base_adr;
          cnt_d     = bus.len_m1;
          clear_acc = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.xin_valid) begin
          beat_d = 1'b1;
          x_d    = bus.xin;
          ptr_d  = ptr_q + MEM_ADR_WIDTH'(1);
          cnt_d  = cnt_q - MEM_ADR_WIDTH'(1);
          if (cnt_q == '0) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (bus.dout_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      x_q     <= x_d;
    end
  end

  // Weight store: non-blocking read/write gives old data on a same-row collision.
  always_ff @(posedge clk) begin
    if (!bus.web) begin
      mem[bus.wadr] <= bus.din;
    end
    if (beat_d) begin
      rd_data_q <= mem[ptr_q];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      logic [MEM_BIT_WIDTH-1:0] w;
      logic [MAG_W-1:0]         mag;
      logic                     sgn;
      logic [ACC_BIT_WIDTH-1:0] mag_ext;
      logic [ACC_BIT_WIDTH-1:0] term;
      logic [ACC_BIT_WIDTH-1:0] acc_q, acc_d;

      assign w       = rd_data_q[gi*MEM_BIT_WIDTH +: MEM_BIT_WIDTH];
      assign mag     = MAG_W'(w[MEM_BIT_WIDTH-2:0]) * MAG_W'(x_q[XIN_BIT_WIDTH-2:0]);
      assign sgn     = w[MEM_BIT_WIDTH-1] ^ x_q[XIN_BIT_WIDTH-1];
      assign mag_ext = ACC_BIT_WIDTH'(mag);
      // A signed zero magnitude negates to zero, so no special case is needed.
      assign term    = sgn ? (-mag_ext) : mag_ext;

      always_comb begin
        acc_d = acc_q;
        if (clear_acc) begin
          acc_d = '0;
        end else if (beat_q) begin
          acc_d = acc_q + term;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign dout_w[gi*ACC_BIT_WIDTH +: ACC_BIT_WIDTH] = acc_q;
    end
  endgenerate

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.xin_ready  = (state_q == S_RUN);
  assign bus.dout_valid = (state_q == S_DONE);
  assign bus.dout       = dout_w;
endmodule

// File: tb/tb_cim_accum_core.sv
// Directed bench for cim_accum_core: table of single-activation jobs plus
// hand-written backpressure, write-collision and mid-job reset sequences.
module tb_cim_accum_core;
  localparam int XW   = 11;
  localparam int MW   = 8;
  localparam int AW   = 4;
  localparam int NC   = 4;
  localparam int ACCW = XW + MW - 1 + AW;
  localparam int DW   = NC * ACCW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_accum_core_if #(.XIN_BIT_WIDTH(XW), .MEM_BIT_WIDTH(MW), .MEM_ADR_WIDTH(AW),
                      .NUM_COL(NC)) bus ();

  cim_accum_core #(.XIN_BIT_WIDTH(XW), .MEM_BIT_WIDTH(MW), .MEM_ADR_WIDTH(AW),
                   .NUM_COL(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string          name;
    int             cfg;
    logic [AW-1:0]  base;
    logic [AW-1:0]  lm1;
    logic [XW-1:0]  x;
    logic [DW-1:0]  exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [DW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {ACCW'(c3), ACCW'(c2), ACCW'(c1), ACCW'(c0)};
  endfunction

  function automatic vec_t mkvec(input string nm, input int cfg, input int base, input int lm1,
                                 input int x, input logic [DW-1:0] exp);
    vec_t v;
    v.name = nm;
    v.cfg  = cfg;
    v.base = AW'(base);
    v.lm1  = AW'(lm1);
    v.x    = XW'(x);
    v.exp  = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic write_row(input int adr, input logic [31:0] data);
    bus.web  = 1'b0;
    bus.wadr = AW'(adr);
    bus.din  = data;
    @(posedge clk); #1;
    bus.web  = 1'b1;
  endtask

  task automatic load_cfg(input int cfg);
    case (cfg)
      0: begin
        for (int r = 0; r < 16; r++) write_row(r, 32'h09090909);
        write_row(0, 32'h007F8503);
      end
      1: begin
        for (int r = 0; r < 16; r++) write_row(r, 32'h7F7F7F7F);
      end
      default: begin
        for (int r = 0; r < 16; r++) write_row(r, 32'h09090909);
        write_row(14, 32'h01010101);
        write_row(15, 32'h02020202);
        write_row(0,  32'h03030303);
        write_row(1,  32'h80808080);
      end
    endcase
  endtask

  // Called #1 after the edge that sampled start; k counts edges since that edge.
  task automatic wait_valid(output int k);
    k = 1;
    while (!bus.dout_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic finish_out(input string nm);
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
    check({nm, "_valid_drop"}, bus.dout_valid, 0);
    check({nm, "_idle"}, bus.busy, 0);
  endtask

  task automatic start_job(input int base, input int lm1, input int x, input logic vld);
    bus.base_adr  = AW'(base);
    bus.len_m1    = AW'(lm1);
    bus.xin       = XW'(x);
    bus.xin_valid = vld;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic run_const_job(input string nm, input int base, input int lm1, input int x,
                               input logic [DW-1:0] exp);
    int k;
    start_job(base, lm1, x, 1'b1);
    wait_valid(k);
    bus.xin_valid = 1'b0;
    check({nm, "_latency"}, k, lm1 + 3);
    check({nm, "_dout"}, bus.dout, exp);
    $display("[TB] job %s base=%0d len_m1=%0d dout=0x%0h", nm, base, lm1, bus.dout);
    finish_out(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int beats;
    int cyc;
    logic [DW-1:0] held;

    vecs[0] = mkvec("single_pos",  0, 0,  0,  2,       pk(6, -10, 254, 0));
    vecs[1] = mkvec("single_neg",  0, 0,  0,  'h407,   pk(-21, 35, -889, 0));
    vecs[2] = mkvec("full_pos",    1, 0,  15, 'h3FF,   pk(2078736, 2078736, 2078736, 2078736));
    vecs[3] = mkvec("full_neg",    1, 0,  15, 'h7FF,   pk(-2078736, -2078736, -2078736, -2078736));
    vecs[4] = mkvec("mid_single",  1, 5,  0,  'h3FF,   pk(129921, 129921, 129921, 129921));
    vecs[5] = mkvec("wrap4",       2, 14, 3,  10,      pk(60, 60, 60, 60));
    vecs[6] = mkvec("wrap2_neg",   2, 15, 1,  'h401,   pk(-5, -5, -5, -5));
    vecs[7] = mkvec("neg_zero",    2, 0,  1,  5,       pk(15, 15, 15, 15));

    rst = 1'b1;
    bus.web = 1'b1; bus.wadr = '0; bus.din = '0;
    bus.start = 1'b0; bus.base_adr = '0; bus.len_m1 = '0;
    bus.xin = '0; bus.xin_valid = 1'b0; bus.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_xin_ready", bus.xin_ready, 0);
    check("reset_dout_valid", bus.dout_valid, 0);
    check("reset_dout", bus.dout, 0);

    for (int i = 0; i < 8; i++) begin
      load_cfg(vecs[i].cfg);
      run_const_job(vecs[i].name, int'(vecs[i].base), int'(vecs[i].lm1), int'(vecs[i].x),
                    vecs[i].exp);
    end

    // Backpressure: valid pattern 1,0,0,1,... with xin = 1,2,3,4 over rows 14,15,0,1.
    load_cfg(2);
    start_job(14, 3, 0, 1'b0);
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 50) begin
      bus.xin_valid = (cyc % 3 == 0);
      bus.xin       = XW'(beats + 1);
      check("bp_ready_in_run", bus.xin_ready, 1);
      if (bus.xin_valid && bus.xin_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.xin_valid = 1'b0;
    check("bp_beats", beats, 4);
    check("bp_drain_ready", bus.xin_ready, 0);
    wait_valid(k);
    check("bp_valid_seen", bus.dout_valid, 1);
    held = pk(14, 14, 14, 14);
    check("bp_dout", bus.dout, held);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("bp_hold_valid", bus.dout_valid, 1);
      check("bp_hold_dout", bus.dout, held);
    end
    $display("[TB] job backpressure dout=0x%0h", bus.dout);
    finish_out("bp");
    check("bp_dout_kept_idle", bus.dout, held);

    // Same-cycle write to the row being read: the old weights must be used.
    load_cfg(2);
    start_job(0, 1, 10, 1'b1);
    write_row(0, 32'h05050505);
    wait_valid(k);
    bus.xin_valid = 1'b0;
    check("hazard_old_data", bus.dout, pk(30, 30, 30, 30));
    $display("[TB] job hazard dout=0x%0h", bus.dout);
    finish_out("hazard");
    run_const_job("hazard_new_data", 0, 1, 10, pk(50, 50, 50, 50));

    // Reset after two of four beats.
    load_cfg(2);
    start_job(14, 3, 10, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.xin_valid = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_xin_ready", bus.xin_ready, 0);
    check("midrst_dout", bus.dout, 0);
    check("midrst_dout_valid", bus.dout_valid, 0);
    $display("[TB] job midrst aborted busy=%0b dout=0x%0h", bus.busy, bus.dout);
    run_const_job("midrst_rerun", 14, 3, 10, pk(60, 60, 60, 60));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
